dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU pipeline's memory stage and a
//  secondary master (DMA/loader port). It sequences every access through a fixed
//  3-state FSM and returns read data with a one-cycle ack. It drives a stall to the
//  CPU pipeline while a CPU request is pending. CPU has priority, with a bounded
//  starvation guarantee for the secondary master.
// PARAMETERS
//  DBITS        32  data width of all data buses
//  ADDR_BITS    11  word-address width of data memory (DMEM_ADDR_BIT_WIDTH)
//  MAX_STARVE   4   max consecutive CPU grants while dmaReq waits; next grant goes to DMA
//  CNT_BITS     3   width of starvation counter; must hold MAX_STARVE
// PORTS
//  clk        in   1          system clock, all state on posedge
//  reset      in   1          asynchronous, active-low reset
//  cpuReq     in   1          CPU access request, held until cpuAck
//  cpuWe      in   1          1 = write, 0 = read
//  cpuAddr    in   ADDR_BITS  CPU word address
//  cpuWdata   in   DBITS      CPU write data
//  cpuAck     out  1          one-cycle pulse, access complete
//  cpuRdata   out  DBITS      read data, valid while cpuAck=1
//  cpuStall   out  1          cpuReq & ~cpuAck (combinational), to pipeline stall mux
//  dmaReq/dmaWe/dmaAddr/dmaWdata  in   as cpu*  secondary master request
//  dmaAck     out  1          as cpuAck
//  dmaRdata   out  DBITS      as cpuRdata
//  memEn      out  1          memory enable
//  memWe      out  1          memory write enable
//  memAddr    out  ADDR_BITS  memory address
//  memWdata   out  DBITS      memory write data
//  memRdata   in   DBITS      synchronous-read memory output, valid 1 cycle after memEn
//  grantDma   out  1          1 while the current/last grant belongs to DMA
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  - States: IDLE -> ACCESS -> RESP -> IDLE. There are no other transitions.
//  - IDLE: arbitrate on the current cycle's requests. If neither request is high, stay in IDLE.
//    Otherwise register the winner's We/Addr/Wdata into the mem* registers and go to ACCESS.
//  - Winner selection:
//    - DMA wins if dmaReq & (~cpuReq | starveCnt == MAX_STARVE).
//    - Otherwise CPU wins.
//  - ACCESS: memEn=1, and memWe=latched We. The write commits at the end of this cycle.
//    Always go to RESP.
//  - RESP: memEn=0 and memWe=0. The winner's Ack=1, and its Rdata=memRdata (writes also ack).
//    The loser's Ack=0. Always go to IDLE.
//  - Latency: request first seen in IDLE at cycle N -> ack at cycle N+2. Minimum period is 3 cycles.
//  - Requester rule: drop or change req in the cycle after ack. IDLE re-samples it.
//  - starveCnt:
//    - On a CPU grant with dmaReq=1, increment (saturate at MAX_STARVE).
//    - On a CPU grant with dmaReq=0, or on any DMA grant, clear to 0.
//  - Rdata outputs are 0 when their Ack=0.
//  - mem* Addr/Wdata hold their value outside ACCESS. Only memEn and memWe qualify them.
//  - Reset (async, mid-operation included) sets these values:
//    - state=IDLE, starveCnt=0, grantDma=0
//    - memEn=0, memWe=0, memAddr=0, memWdata=0
//    - cpuAck=0, dmaAck=0, cpuRdata=0, dmaRdata=0, busy=0
//    An access in flight is dropped with no ack. A write is aborted if reset lands before the ACCESS edge.
//  - Requests arriving in ACCESS or RESP are ignored until IDLE. They are not queued, so requesters must hold req.
//  - Simultaneous requests with starveCnt < MAX_STARVE: CPU wins.
// TESTING
//  1. Reset low, random req inputs -> all outputs 0 and busy=0. Release reset -> IDLE.
//  2. CPU write addr 0x010 data 0xDEADBEEF, then CPU read 0x010.
//     Required: memWe=1 only in ACCESS; read cpuAck at N+2 with cpuRdata=0xDEADBEEF; dmaAck stays 0.
//  3. cpuReq and dmaReq both held high continuously.
//     Required grant order: CPU,CPU,CPU,CPU,DMA, then repeat. starveCnt reaches 4 and then clears.
//  4. DMA-only read of 0x7FF preloaded with 0x12345678.
//     Required: dmaAck at N+2, dmaRdata=0x12345678, grantDma=1, cpuStall=0.
//  5. CPU read pending while a DMA access is in ACCESS.
//     Required: cpuStall=1 through the DMA's RESP; CPU is granted in the next IDLE; cpuAck 3 cycles later.
//  6. CPU write, reset asserted during IDLE->ACCESS, reset released.
//     Required: no ack, memWe never 1, memory word unchanged, FSM in IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port synchronous data memory between the CPU memory stage
// and a secondary (DMA/loader) master; fixed IDLE->ACCESS->RESP sequence per access.
module dmem_arbiter #(
   parameter int unsigned DBITS      = 32,
   parameter int unsigned ADDR_BITS  = 11,
   parameter int unsigned MAX_STARVE = 4,
   parameter int unsigned CNT_BITS   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpuReq,
   input  logic                 cpuWe,
   input  logic [ADDR_BITS-1:0] cpuAddr,
   input  logic [DBITS-1:0]     cpuWdata,
   output logic                 cpuAck,
   output logic [DBITS-1:0]     cpuRdata,
   output logic                 cpuStall,
   input  logic                 dmaReq,
   input  logic                 dmaWe,
   input  logic [ADDR_BITS-1:0] dmaAddr,
   input  logic [DBITS-1:0]     dmaWdata,
   output logic                 dmaAck,
   output logic [DBITS-1:0]     dmaRdata,
   output logic                 memEn,
   output logic                 memWe,
   output logic [ADDR_BITS-1:0] memAddr,
   output logic [DBITS-1:0]     memWdata,
   input  logic [DBITS-1:0]     memRdata,
   output logic                 grantDma,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [CNT_BITS-1:0] STARVE_LIMIT = CNT_BITS'(MAX_STARVE);

   state_t                state, state_d;
   logic [CNT_BITS-1:0]   starve_cnt, starve_cnt_d;
   logic                  grant_dma, grant_dma_d;
   logic                  mem_en, mem_en_d;
   logic                  mem_we, mem_we_d;
   logic [ADDR_BITS-1:0]  mem_addr, mem_addr_d;
   logic [DBITS-1:0]      mem_wdata, mem_wdata_d;
   logic                  cpu_ack, cpu_ack_d;
   logic                  dma_ack, dma_ack_d;
   logic                  dma_wins;

   // DMA takes the slot when the CPU is idle or has starved it for MAX_STARVE grants
   assign dma_wins = dmaReq & (~cpuReq | (starve_cnt == STARVE_LIMIT));

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         grant_dma  <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_ack    <= 1'b0;
         dma_ack    <= 1'b0;
      end else begin
         state      <= state_d;
         starve_cnt <= starve_cnt_d;
         grant_dma  <= grant_dma_d;
         mem_en     <= mem_en_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         cpu_ack    <= cpu_ack_d;
         dma_ack    <= dma_ack_d;
      end
   end

   // Next state; enables/acks are staged one cycle ahead so they are live in ACCESS/RESP
   always_comb begin
      state_d      = state;
      starve_cnt_d = starve_cnt;
      grant_dma_d  = grant_dma;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      cpu_ack_d    = 1'b0;
      dma_ack_d    = 1'b0;
      case (state)
         IDLE: begin
            if (cpuReq | dmaReq) begin
               state_d  = ACCESS;
               mem_en_d = 1'b1;
               if (dma_wins) begin
                  grant_dma_d  = 1'b1;
                  mem_we_d     = dmaWe;
                  mem_addr_d   = dmaAddr;
                  mem_wdata_d  = dmaWdata;
                  starve_cnt_d = '0;
               end else begin
                  grant_dma_d = 1'b0;
                  mem_we_d    = cpuWe;
                  mem_addr_d  = cpuAddr;
                  mem_wdata_d = cpuWdata;
                  if (!dmaReq)
                     starve_cnt_d = '0;
                  else if (starve_cnt != STARVE_LIMIT)
                     starve_cnt_d = starve_cnt + CNT_BITS'(1);
               end
            end
         end
         ACCESS: begin
            state_d   = RESP;
            cpu_ack_d = ~grant_dma;
            dma_ack_d = grant_dma;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read data arrives from the memory register during RESP, so it is gated, not re-registered
   assign cpuRdata = cpu_ack ? memRdata : '0;
   assign dmaRdata = dma_ack ? memRdata : '0;
   assign cpuStall = cpuReq & ~cpu_ack;

   assign cpuAck   = cpu_ack;
   assign dmaAck   = dma_ack;
   assign memEn    = mem_en;
   assign memWe    = mem_we;
   assign memAddr  = mem_addr;
   assign memWdata = mem_wdata;
   assign grantDma = grant_dma;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model and
// hand-computed expectations at each step.
module tb_dmem_arbiter;

   localparam int unsigned DBITS     = 32;
   localparam int unsigned ADDR_BITS = 11;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 cpuReq, cpuWe, cpuAck, cpuStall;
   logic [ADDR_BITS-1:0] cpuAddr;
   logic [DBITS-1:0]     cpuWdata, cpuRdata;
   logic                 dmaReq, dmaWe, dmaAck;
   logic [ADDR_BITS-1:0] dmaAddr;
   logic [DBITS-1:0]     dmaWdata, dmaRdata;
   logic                 memEn, memWe;
   logic [ADDR_BITS-1:0] memAddr;
   logic [DBITS-1:0]     memWdata, memRdata;
   logic                 grantDma, busy;

   logic [DBITS-1:0]     mem [0:(1<<ADDR_BITS)-1];
   logic                 pre_en;
   logic [ADDR_BITS-1:0] pre_addr;
   logic [DBITS-1:0]     pre_data;
   logic                 watch;
   logic                 we_seen = 1'b0;

   int tests = 0;
   int fails = 0;
   logic exp_dma;
   int   exp_cnt;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
      .cpuAck(cpuAck), .cpuRdata(cpuRdata), .cpuStall(cpuStall),
      .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWdata(dmaWdata),
      .dmaAck(dmaAck), .dmaRdata(dmaRdata),
      .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata), .grantDma(grantDma), .busy(busy)
   );

   always #5 clk = ~clk;

   // Single-port synchronous memory, read-first; pre_en is a backdoor preload
   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else if (memEn) begin
         if (memWe) mem[memAddr] <= memWdata;
         memRdata <= mem[memAddr];
      end
   end

   always @(posedge clk) begin
      if (watch && memWe) we_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
      dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = '0; dmaWdata = '0;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      watch = 1'b0;

      // Reset held with random requests
      for (int i = 0; i < 4; i++) begin
         cpuReq = 1'($urandom); cpuWe = 1'($urandom); cpuAddr = 11'($urandom);
         dmaReq = 1'($urandom); dmaWe = 1'($urandom); dmaAddr = 11'($urandom);
         cpuWdata = $urandom; dmaWdata = $urandom;
         tick;
         check("rst_stall", 32'(cpuStall), 32'(cpuReq));
      end
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_acks", 32'({cpuAck, dmaAck}), 32'd0);
      check("rst_rdata", cpuRdata | dmaRdata, 32'd0);
      check("rst_memctl", 32'({memEn, memWe, grantDma}), 32'd0);
      check("rst_memaddr", 32'(memAddr), 32'd0);
      check("rst_memwdata", memWdata, 32'd0);
      cpuReq = 1'b0; dmaReq = 1'b0; cpuWe = 1'b0; dmaWe = 1'b0;
      reset = 1'b1;
      tick;
      check("rel_busy", 32'(busy), 32'd0);

      // CPU write then read-back
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 11'h010; cpuWdata = 32'hDEADBEEF;
      tick;
      check("wr_access_en_we", 32'({memEn, memWe}), 32'h3);
      check("wr_access_addr", 32'(memAddr), 32'h010);
      check("wr_access_wdata", memWdata, 32'hDEADBEEF);
      check("wr_access_stall", 32'({cpuStall, busy}), 32'h3);
      tick;
      check("wr_resp_ack", 32'({cpuAck, dmaAck}), 32'h2);
      check("wr_resp_en_we", 32'({memEn, memWe}), 32'h0);
      check("wr_resp_stall", 32'(cpuStall), 32'd0);
      cpuWe = 1'b0; cpuWdata = '0;
      tick;
      check("rd_idle", 32'({busy, cpuAck, cpuStall, memWe}), 32'h2);
      tick;
      check("rd_access", 32'({memEn, memWe}), 32'h2);
      tick;
      check("rd_resp_ack", 32'({cpuAck, dmaAck}), 32'h2);
      check("rd_resp_data", cpuRdata, 32'hDEADBEEF);
      check("rd_resp_dmadata", dmaRdata, 32'd0);
      check("rd_starve", 32'(dut.starve_cnt), 32'd0);
      cpuReq = 1'b0;
      tick;

      // Both masters held: four CPU grants, then one DMA grant, repeated
      cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 11'h010;
      dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 11'h010;
      for (int g = 0; g < 10; g++) begin
         exp_dma = ((g % 5) == 4);
         exp_cnt = exp_dma ? 0 : (g % 5) + 1;
         tick;
         check("arb_access_grant", 32'(grantDma), 32'(exp_dma));
         tick;
         check("arb_cpuack", 32'(cpuAck), 32'(!exp_dma));
         check("arb_dmaack", 32'(dmaAck), 32'(exp_dma));
         check("arb_starve", 32'(dut.starve_cnt), 32'(exp_cnt));
         check("arb_cpurdata", cpuRdata, exp_dma ? 32'd0 : 32'hDEADBEEF);
         check("arb_dmardata", dmaRdata, exp_dma ? 32'hDEADBEEF : 32'd0);
         tick;
      end
      cpuReq = 1'b0; dmaReq = 1'b0;

      // DMA-only read of the top word
      pre_en = 1'b1; pre_addr = 11'h7FF; pre_data = 32'h12345678;
      tick;
      pre_en = 1'b0;
      dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 11'h7FF;
      tick;
      check("dma_access", 32'({grantDma, cpuStall, memEn}), 32'h5);
      check("dma_access_addr", 32'(memAddr), 32'h7FF);
      tick;
      check("dma_resp_ack", 32'({cpuAck, dmaAck}), 32'h1);
      check("dma_resp_data", dmaRdata, 32'h12345678);
      check("dma_resp_stall", 32'(cpuStall), 32'd0);
      dmaReq = 1'b0;
      tick;

      // CPU request arrives while a DMA access is in flight
      dmaReq = 1'b1; dmaAddr = 11'h7FF;
      tick;
      check("blk_dma_grant", 32'(grantDma), 32'd1);
      cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 11'h010;
      #1;
      check("blk_stall_access", 32'(cpuStall), 32'd1);
      tick;
      check("blk_dma_ack", 32'({dmaAck, cpuAck, cpuStall}), 32'h5);
      dmaReq = 1'b0;
      tick;
      check("blk_idle", 32'({busy, cpuStall}), 32'h1);
      tick;
      check("blk_cpu_grant", 32'({grantDma, memEn}), 32'h1);
      check("blk_cpu_addr", 32'(memAddr), 32'h010);
      tick;
      check("blk_cpu_ack", 32'({cpuAck, cpuStall, dmaAck}), 32'h4);
      check("blk_cpu_data", cpuRdata, 32'hDEADBEEF);
      cpuReq = 1'b0;
      tick;

      // Reset lands before the IDLE->ACCESS edge of a CPU write
      pre_en = 1'b1; pre_addr = 11'h055; pre_data = 32'hA5A5A5A5;
      tick;
      pre_en = 1'b0;
      watch = 1'b1;
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 11'h055; cpuWdata = 32'h11111111;
      #2;
      reset = 1'b0;
      #1;
      check("abort_busy", 32'({busy, memEn, memWe}), 32'd0);
      tick;
      cpuReq = 1'b0; cpuWe = 1'b0;
      tick;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("abort_noack", 32'({cpuAck, dmaAck, busy}), 32'd0);
      end
      watch = 1'b0;
      check("abort_we_seen", 32'(we_seen), 32'd0);
      check("abort_mem", mem[11'h055], 32'hA5A5A5A5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
